cpu_ma_split: RTL
=================

// Module: cpu_ma_split
// PURPOSE
//  Parametrised memory-access stage between EX and WB. Drives a req/gnt/rvalid
//  data-memory port with wait states. Splits misaligned loads/stores into two
//  aligned bus beats. Merges and sign/zero-extends load data, so WB receives
//  final register data. Stalls upstream via ready_o while a transaction runs.
// PARAMETERS
//  XLEN             32  data/address width (32 or 64); bus is BB=XLEN/8 bytes
//  SPLIT_MISALIGNED 1   1: split accesses that cross a bus word; 0: flag fault
// PORTS
//  clk_i           in   1     clock
//  rst_ni          in   1     async active-low reset
//  valid_i         in   1     upstream instruction valid
//  ready_o         out  1     stage can accept (1 only in IDLE)
//  pc_i/ir_i       in   XLEN/32  program counter / instruction
//  ma_addr_i       in   XLEN  byte address
//  ma_mode_i       in   2     MA_X / MA_LOAD / MA_STORE
//  ma_size_i       in   2     0=B 1=H 2=W 3=D (D legal only XLEN=64)
//  ma_signed_i     in   1     sign-extend load result
//  ma_data_i       in   XLEN  store data, LSB-justified
//  wb_data_i       in   XLEN  non-load write-back data
//  wb_valid_i      in   1     write-back valid
//  dmem_req_o      out  1     request; held with payload stable until gnt
//  dmem_gnt_i      in   1     request accepted this cycle
//  dmem_addr_o     out  XLEN  bus-word-aligned address
//  dmem_we_o       out  1     1=write beat
//  dmem_wmask_o    out  BB    byte enables (0 on reads)
//  dmem_wdata_o    out  XLEN  write data, byte lanes positioned
//  dmem_rvalid_i   in   1     read data valid (>=1 cycle after its gnt)
//  dmem_rdata_i    in   XLEN  read data
//  valid_o         out  1     result valid, one-cycle pulse per instruction
//  pc_o/ir_o       out  XLEN/32  retired pc / ir
//  wb_data_o       out  XLEN  final write-back data
//  wb_valid_o      out  1     write register file
//  fault_o         out  1     misaligned (SPLIT=0) or illegal size
// BEHAVIOUR
//  Reset: state IDLE, dmem_req_o=0, valid_o=0, pc_o=NOP_PC, ir_o=NOP_IR,
//   wb_data_o=0, wb_valid_o=0, fault_o=0; reset mid-transaction drops req
//   immediately; any later rvalid is ignored in IDLE.
//  FSM: IDLE -> REQ0 -> (load) WAIT0 -> [REQ1 -> (load) WAIT1] -> IDLE.
//  Accept on valid_i&&ready_o. MA_X or fault: 1-cycle registered pass-through,
//   valid_o next cycle, memory untouched; fault forces wb_valid_o=0.
//  off=addr%BB, n=1<<size. split = off+n>BB. Beat0 addr=addr&~(BB-1),
//   mask=((1<<n)-1)<<off truncated to BB, wdata=data<<8*off.
//   Beat1 addr=beat0+BB (wraps modulo 2^XLEN), mask=(1<<n)-1>>(BB-off),
//   wdata=data>>8*(BB-off).
//  REQx: store leaves on gnt (to REQ1 if split and beat0, else done);
//   load goes to WAITx on gnt, captures rdata on rvalid.
//  Done: result registered; valid_o pulses the cycle after the final gnt
//   (store) or rvalid (load); FSM returns to IDLE in that same cycle.
//  Load result = ({beat1,beat0} >> 8*off) truncated to n bytes, then
//   sign-extended if ma_signed_i, else zero-extended.
//  Store: wb_valid_o=0. Load: wb_valid_o=wb_valid_i latched at accept.
//  Min latency: MA_X 1 cycle; aligned load with gnt at once, rvalid +1 = 3;
//   split load = 5.
// TESTING
//  XLEN=32 LW 0x100, gnt immediate, rvalid +1 =0xDEADBEEF -> wb_data_o=0xDEADBEEF, valid_o 3rd cycle.
//  SW 0x0000_0103 data 0x11223344 -> beat0 0x100 mask 1000 wdata 0x44000000; beat1 0x104 mask 0111 wdata 0x00112233.
//  LH signed 0x103, rdata 0xAB000000 then 0x000000CD -> wb_data_o=0xFFFFCDAB.
//  gnt held low 4 cycles -> req/addr/mask stable, ready_o=0 throughout.
//  SPLIT_MISALIGNED=0, LW 0x102 -> no dmem_req_o, fault_o=1, wb_valid_o=0.
//  rst_ni low while in WAIT0 -> req 0 at once, post-reset rvalid ignored, ready_o=1.

Source files
------------

// File: rtl/cpu_ma_split_if.sv
// Data-memory port of the memory-access stage: req/gnt request channel with a
// separate rvalid/rdata read-return channel.
interface cpu_ma_split_if #(
  parameter int XLEN = 32
);
  localparam int BB = XLEN / 8;

  logic            req;
  logic            gnt;
  logic [XLEN-1:0] addr;
  logic            we;
  logic [BB-1:0]   wmask;
  logic [XLEN-1:0] wdata;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, addr, we, wmask, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, wmask, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/cpu_ma_split.sv
// Memory-access stage between EX and WB: issues aligned bus beats (two for an
// access that crosses a bus word) and hands WB the merged, extended load data.
module cpu_ma_split #(
  parameter int              XLEN             = 32,
  parameter int              SPLIT_MISALIGNED = 1,
  parameter logic [XLEN-1:0] NOP_PC           = '0,
  parameter logic [31:0]     NOP_IR           = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [31:0]           ir_i,
  input  logic [XLEN-1:0]       ma_addr_i,
  input  logic [1:0]            ma_mode_i,
  input  logic [1:0]            ma_size_i,
  input  logic                  ma_signed_i,
  input  logic [XLEN-1:0]       ma_data_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic                  wb_valid_i,
  cpu_ma_split_if.master        dmem,
  output logic                  valid_o,
  output logic [XLEN-1:0]       pc_o,
  output logic [31:0]           ir_o,
  output logic [XLEN-1:0]       wb_data_o,
  output logic                  wb_valid_o,
  output logic                  fault_o
);
  localparam int BB = XLEN / 8;
  localparam int OW = $clog2(BB);
  localparam logic [1:0] MA_LOAD  = 2'd1;
  localparam logic [1:0] MA_STORE = 2'd2;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1} state_t;
  state_t state_q, state_d;

  // One bit per byte of an n-byte access, before lane positioning.
  function automatic logic [2*BB-1:0] byte_mask(input logic [1:0] size);
    logic [2*BB-1:0] m;
    int              nb;
    nb = 1 << size;
    for (int b = 0; b < 2*BB; b++) m[b] = (b < nb);
    return m;
  endfunction

  // Shift the two-beat window down to the access, keep n bytes, extend.
  function automatic logic [XLEN-1:0] load_fmt(input logic [2*XLEN-1:0] pair,
                                              input logic [OW-1:0]     off,
                                              input logic [1:0]        size,
                                              input logic              sgn);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   r;
    logic              sbit;
    int                nb;
    sh = pair >> {off, 3'b000};
    r  = sh[XLEN-1:0];
    nb = 1 << size;
    case (size)
      2'd0:    sbit = r[7];
      2'd1:    sbit = r[15];
      2'd2:    sbit = r[31];
      default: sbit = r[XLEN-1];
    endcase
    for (int b = 0; b < BB; b++)
      if (b >= nb) r[8*b +: 8] = {8{sgn & sbit}};
    return r;
  endfunction

  logic [OW-1:0] off_in;
  int            nb_in;
  logic          is_mem, split_in, fault_in, go_mem, accept;

  always_comb begin
    off_in   = ma_addr_i[OW-1:0];
    nb_in    = 1 << ma_size_i;
    is_mem   = (ma_mode_i == MA_LOAD) || (ma_mode_i == MA_STORE);
    split_in = (int'(off_in) + nb_in) > BB;
    fault_in = is_mem && ((nb_in > BB) || ((SPLIT_MISALIGNED == 0) && split_in));
    go_mem   = is_mem && !fault_in;
  end

  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i && ready_o;

  // ---- accept: capture the instruction for the duration of the transaction
  logic [XLEN-1:0] addr_p0, data_p0, pc_p0, wbd_p0, rdata0_p0;
  logic [31:0]     ir_p0;
  logic [1:0]      size_p0;
  logic            sgn_p0, load_p0, wbv_p0, split_p0, cap0;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_p0  <= ma_addr_i;
      data_p0  <= ma_data_i;
      size_p0  <= ma_size_i;
      sgn_p0   <= ma_signed_i;
      load_p0  <= (ma_mode_i == MA_LOAD);
      split_p0 <= split_in;
      pc_p0    <= pc_i;
      ir_p0    <= ir_i;
      wbd_p0   <= wb_data_i;
      wbv_p0   <= wb_valid_i;
    end
    if (cap0) rdata0_p0 <= dmem.rdata;
  end

  // ---- bus beats: geometry derived from the captured access
  logic [OW-1:0]     off_q;
  logic [2*BB-1:0]   mask2;
  logic [2*XLEN-1:0] wdata2, pair;
  logic [XLEN-1:0]   base, load_res;
  logic              on_beat1;

  always_comb begin
    off_q    = addr_p0[OW-1:0];
    mask2    = byte_mask(size_p0) << off_q;
    wdata2   = {{XLEN{1'b0}}, data_p0} << {off_q, 3'b000};
    base     = {addr_p0[XLEN-1:OW], {OW{1'b0}}};
    on_beat1 = (state_q == REQ1) || (state_q == WAIT1);
    pair     = (state_q == WAIT1) ? {dmem.rdata, rdata0_p0} : {{XLEN{1'b0}}, dmem.rdata};
    load_res = load_fmt(pair, off_q, size_p0, sgn_p0);
  end

  assign dmem.req   = (state_q == REQ0) || (state_q == REQ1);
  assign dmem.addr  = on_beat1 ? base + XLEN'(BB) : base;
  assign dmem.we    = !load_p0;
  assign dmem.wmask = load_p0 ? '0 : (on_beat1 ? mask2[2*BB-1:BB] : mask2[BB-1:0]);
  assign dmem.wdata = on_beat1 ? wdata2[2*XLEN-1:XLEN] : wdata2[XLEN-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  logic done;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    cap0    = 1'b0;
    case (state_q)
      IDLE:  if (accept && go_mem) state_d = REQ0;
      REQ0:
        if (dmem.gnt) begin
          if (load_p0)       state_d = WAIT0;
          else if (split_p0) state_d = REQ1;
          else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      WAIT0:
        if (dmem.rvalid) begin
          if (split_p0) begin
            cap0    = 1'b1;
            state_d = REQ1;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      REQ1:
        if (dmem.gnt) begin
          if (load_p0) state_d = WAIT1;
          else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      WAIT1:
        if (dmem.rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  // ---- retire: pass-through/fault retires on accept, memory ops on done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o    <= 1'b0;
      pc_o       <= NOP_PC;
      ir_o       <= NOP_IR;
      wb_data_o  <= '0;
      wb_valid_o <= 1'b0;
      fault_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept && !go_mem) begin
        valid_o    <= 1'b1;
        pc_o       <= pc_i;
        ir_o       <= ir_i;
        wb_data_o  <= wb_data_i;
        wb_valid_o <= wb_valid_i && !fault_in;
        fault_o    <= fault_in;
      end else if (done) begin
        valid_o    <= 1'b1;
        pc_o       <= pc_p0;
        ir_o       <= ir_p0;
        wb_data_o  <= load_p0 ? load_res : wbd_p0;
        wb_valid_o <= load_p0 && wbv_p0;
        fault_o    <= 1'b0;
      end
    end
  end
endmodule
